uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin arbiter that gives four byte-stream requesters
//            packet-locked access to a single UART transmitter.
//
//            A requester wins the UART in IDLE and keeps it until the byte it
//            flagged with req_last has been shifted out and the inter-byte gap
//            has elapsed. Each accepted byte produces a one-cycle ld_tx_data
//            strobe to the UART and a matching req_ack pulse to the requester.
//
// Parameters:
//   GAP      - idle cycles inserted after each byte completes (0..15)
//   TIMEOUT  - stall limit in cycles while the owner withholds its next byte
//              (only used when UART_ARB_TIMEOUT_EN is defined)
//
// Optional feature (macro UART_ARB_TIMEOUT_EN):
//   defined   - an owner that drops req mid-packet for TIMEOUT cycles loses
//               the grant and timeout_err pulses for one cycle
//   undefined - LOAD waits indefinitely and timeout_err is tied low
//
// Ports:
//   txclk        in   UART TX bit clock, all logic on the rising edge
//   reset_n      in   asynchronous active-low reset
//   req[3:0]     in   per-requester byte valid, held until acked
//   req_last[3:0]in   per-requester "this byte ends the packet"
//   req_data[31:0]in  requester i byte on bits [8i+7:8i]
//   req_ack[3:0] out  one-cycle pulse, byte accepted from requester i
//   grant[3:0]   out  one-hot owner of the UART, zero when idle
//   ld_tx_data   out  one-cycle load strobe to the UART
//   tx_data[7:0] out  byte to the UART, valid with ld_tx_data
//   tx_enable    out  UART enable level, high while a packet is owned
//   tx_empty     in   UART transmitter empty flag
//   timeout_err  out  one-cycle pulse when a stalled owner is released
//
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int GAP     = 1,
    parameter int TIMEOUT = 4096
) (
    input  logic        txclk,
    input  logic        reset_n,
    input  logic [3:0]  req,
    input  logic [3:0]  req_last,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ack,
    output logic [3:0]  grant,
    output logic        ld_tx_data,
    output logic [7:0]  tx_data,
    output logic        tx_enable,
    input  logic        tx_empty,
    output logic        timeout_err
);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_LOAD      = 3'd1;
    localparam logic [2:0] c_ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] c_ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] c_ST_GAP       = 3'd4;

    localparam logic       c_NO_GAP   = (GAP == 0);
    localparam logic [3:0] c_GAP_LAST = 4'(GAP - 1);

    logic [2:0] r_state;
    logic       r_armed;     // first edge after reset release only arms the arbiter
    logic [3:0] r_grant;
    logic [1:0] r_gidx;      // index of the current owner
    logic [1:0] r_ptr;       // highest-priority requester for the next arbitration
    logic [3:0] r_ack;
    logic       r_ld;
    logic [7:0] r_tx_data;
    logic       r_tx_en;
    logic       r_last;      // latched req_last of the byte in flight
    logic [3:0] r_gap_cnt;

    // ------------------------------------------------------------------------
    // Round-robin pick: scan from r_ptr upwards; iterating from the far end
    // downwards lets the nearest requester overwrite the others.
    // ------------------------------------------------------------------------
    logic       w_any_req;
    logic [1:0] w_pick;
    logic [1:0] w_cand;

    always_comb begin
        w_any_req = |req;
        w_pick    = r_ptr;
        w_cand    = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_cand = r_ptr + 2'(k);
            if (req[w_cand]) begin
                w_pick = w_cand;
            end
        end
    end

    logic       w_owner_req;
    logic [7:0] w_owner_byte;
    logic       w_byte_done;  // byte shifted out and gap (if any) elapsed

    assign w_owner_req  = req[r_gidx];
    assign w_owner_byte = req_data[{r_gidx, 3'b000} +: 8];
    assign w_byte_done  = ((r_state == c_ST_WAIT_DONE) && tx_empty && c_NO_GAP) ||
                          ((r_state == c_ST_GAP) && (r_gap_cnt == c_GAP_LAST));

`ifdef UART_ARB_TIMEOUT_EN
    localparam int                c_TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT - 1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_timeout_err;

    assign timeout_err = r_timeout_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT == 0);
    assign timeout_err      = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Arbiter FSM, all outputs registered
    // ------------------------------------------------------------------------
    always_ff @(posedge txclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= c_ST_IDLE;
            r_armed   <= 1'b0;
            r_grant   <= 4'b0000;
            r_gidx    <= 2'd0;
            r_ptr     <= 2'd0;
            r_ack     <= 4'b0000;
            r_ld      <= 1'b0;
            r_tx_data <= 8'h00;
            r_tx_en   <= 1'b0;
            r_last    <= 1'b0;
            r_gap_cnt <= 4'd0;
`ifdef UART_ARB_TIMEOUT_EN
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_armed <= 1'b1;
            r_ack   <= 4'b0000;
            r_ld    <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
            case (r_state)
                c_ST_IDLE: begin
                    if (r_armed && w_any_req) begin
                        r_grant <= 4'b0001 << w_pick;
                        r_gidx  <= w_pick;
                        r_ptr   <= w_pick + 2'd1;  // winner drops to lowest priority
                        r_tx_en <= 1'b1;
                        r_state <= c_ST_LOAD;
                    end
                end

                c_ST_LOAD: begin
                    if (w_owner_req && tx_empty) begin
                        r_ld      <= 1'b1;
                        r_ack     <= 4'b0001 << r_gidx;
                        r_tx_data <= w_owner_byte;
                        r_last    <= req_last[r_gidx];
                        r_state   <= c_ST_WAIT_BUSY;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    // Only an absent owner byte counts as a stall; a busy
                    // UART with a byte waiting does not.
                    if (w_owner_req) begin
                        r_to_cnt <= '0;
                    end else if (r_to_cnt == c_TO_LAST) begin
                        r_to_cnt      <= '0;
                        r_timeout_err <= 1'b1;
                        r_grant       <= 4'b0000;
                        r_tx_en       <= 1'b0;
                        r_state       <= c_ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end

                c_ST_WAIT_BUSY: begin
                    if (!tx_empty) begin
                        r_state <= c_ST_WAIT_DONE;
                    end
                end

                c_ST_WAIT_DONE, c_ST_GAP: begin
                    if (w_byte_done) begin
                        if (r_last) begin
                            r_grant <= 4'b0000;
                            r_tx_en <= 1'b0;
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_state <= c_ST_LOAD;
                        end
                    end else if (r_state == c_ST_WAIT_DONE) begin
                        if (tx_empty) begin
                            r_gap_cnt <= 4'd0;
                            r_state   <= c_ST_GAP;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 4'd1;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign req_ack    = r_ack;
    assign grant      = r_grant;
    assign ld_tx_data = r_ld;
    assign tx_data    = r_tx_data;
    assign tx_enable  = r_tx_en;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Self-checking bench for uart_tx_arbiter. Four requester queues
//            and a simple UART model (busy for a fixed number of cycles after
//            each load) drive the DUT; a scoreboard of {owner, byte} entries
//            is checked at every ld_tx_data strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int c_GAP      = 1;
    localparam int c_TIMEOUT  = 16;
    localparam int c_UART_LEN = 6;

    logic        txclk;
    logic        reset_n;
    logic [3:0]  req;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic [3:0]  grant;
    logic        ld_tx_data;
    logic [7:0]  tx_data;
    logic        tx_enable;
    logic        tx_empty;
    logic        timeout_err;

    uart_tx_arbiter #(
        .GAP     (c_GAP),
        .TIMEOUT (c_TIMEOUT)
    ) dut (
        .txclk       (txclk),
        .reset_n     (reset_n),
        .req         (req),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .grant       (grant),
        .ld_tx_data  (ld_tx_data),
        .tx_data     (tx_data),
        .tx_enable   (tx_enable),
        .tx_empty    (tx_empty),
        .timeout_err (timeout_err)
    );

    initial begin
        txclk = 1'b0;
        forever #5 txclk = ~txclk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] q_req [4][$];  // {last, data}
    logic [9:0] q_exp [$];     // {owner index, data}
    int         busy;
    bit         stall;
    bit  [3:0]  en;
    int         acks [4];
    int         cyc_n;
    int         last_ld_cyc;

    // ------------------------------------------------------------------------
    // Requester + UART model and scoreboard, evaluated 1 ns after each edge
    // ------------------------------------------------------------------------
    initial begin
        logic [9:0] e;
        logic [3:0] e_oh;
        logic [8:0] head;
        req         = 4'b0;
        req_last    = 4'b0;
        req_data    = 32'b0;
        tx_empty    = 1'b1;
        busy        = 0;
        stall       = 1'b0;
        en          = 4'hF;
        cyc_n       = 0;
        last_ld_cyc = -100;
        forever begin
            @(posedge txclk);
            #1;
            cyc_n++;
            if (ld_tx_data === 1'b1) begin
                n_tests++;
                if (q_exp.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_ld: got tx_data=%h grant=%b, required no load", tx_data, grant);
                end else begin
                    e    = q_exp.pop_front();
                    e_oh = 4'b0001 << e[9:8];
                    if (tx_data !== e[7:0] || grant !== e_oh || req_ack !== e_oh) begin
                        n_fail++;
                        $display("FAIL sb_load: got data=%h grant=%b ack=%b, required data=%h grant=%b ack=%b",
                                 tx_data, grant, req_ack, e[7:0], e_oh, e_oh);
                    end
                end
                n_tests++;
                if (cyc_n - last_ld_cyc < 2 + c_GAP) begin
                    n_fail++;
                    $display("FAIL ld_spacing: got %0d cycles, required >= %0d", cyc_n - last_ld_cyc, 2 + c_GAP);
                end
                last_ld_cyc = cyc_n;
                busy = c_UART_LEN;
            end else if (busy > 0) begin
                busy--;
            end
            n_tests++;
            if (req_ack !== 4'b0 && ld_tx_data !== 1'b1) begin
                n_fail++;
                $display("FAIL ack_without_ld: got ack=%b ld=%b, required ack only with ld", req_ack, ld_tx_data);
            end
            n_tests++;
            if (tx_enable !== (grant != 4'b0)) begin
                n_fail++;
                $display("FAIL enable_vs_grant: got tx_enable=%b grant=%b, required tx_enable=|grant", tx_enable, grant);
            end
            for (int i = 0; i < 4; i++) begin
                if (req_ack[i] === 1'b1 && q_req[i].size() > 0) begin
                    void'(q_req[i].pop_front());
                    acks[i]++;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (en[i] && q_req[i].size() > 0) begin
                    head              = q_req[i][0];
                    req[i]            = 1'b1;
                    req_last[i]       = head[8];
                    req_data[8*i +: 8] = head[7:0];
                end else begin
                    req[i]      = 1'b0;
                    req_last[i] = 1'b0;
                end
            end
            tx_empty = (busy == 0) && !stall;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish within 1 ms");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge txclk);
        #2;
    endtask

    // Asserts reset and clears all model state; reset stays low on return.
    task automatic do_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            q_req[i].delete();
            acks[i] = 0;
        end
        q_exp.delete();
        busy        = 0;
        stall       = 1'b0;
        en          = 4'hF;
        last_ld_cyc = -100;
        cyc();
        cyc();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (grant !== 4'b0)     begin n_fail++; $display("FAIL rst_grant: got %b, required 0000", grant); end
        n_tests++; if (req_ack !== 4'b0)   begin n_fail++; $display("FAIL rst_ack: got %b, required 0000", req_ack); end
        n_tests++; if (ld_tx_data !== 1'b0) begin n_fail++; $display("FAIL rst_ld: got %b, required 0", ld_tx_data); end
        n_tests++; if (tx_data !== 8'h00)  begin n_fail++; $display("FAIL rst_tx_data: got %h, required 00", tx_data); end
        n_tests++; if (tx_enable !== 1'b0) begin n_fail++; $display("FAIL rst_tx_enable: got %b, required 0", tx_enable); end
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_timeout_err: got %b, required 0", timeout_err); end
        reset_n = 1'b1;
        repeat (3) cyc();
        n_tests++; if (grant !== 4'b0) begin n_fail++; $display("FAIL idle_no_req_grant: got %b, required 0000", grant); end
    endtask

    task automatic test_contention();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q_req[i].push_back({1'b1, 8'hC0 + 8'(i)});
            q_exp.push_back({2'(i), 8'hC0 + 8'(i)});
        end
        cyc();
        reset_n = 1'b1;
        cyc();
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL first_edge_grant: got %b, required 0000", grant); end
        cyc();
        n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL second_edge_grant: got %b, required 0001", grant); end
        for (int t = 0; t < 400 && q_exp.size() != 0; t++) cyc();
        n_tests++; if (q_exp.size() != 0) begin n_fail++; $display("FAIL rr_drain: got %0d loads pending, required 0", q_exp.size()); end
        repeat (12) cyc();
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (acks[i] != 1) begin n_fail++; $display("FAIL rr_acks[%0d]: got %0d, required 1", i, acks[i]); end
        end
        n_tests++; if (grant !== 4'b0 || tx_enable !== 1'b0) begin n_fail++; $display("FAIL rr_release: got grant=%b en=%b, required 0000/0", grant, tx_enable); end
    endtask

    task automatic test_single();
        int k;
        do_reset();
        q_req[0].push_back({1'b0, 8'h55});
        q_req[0].push_back({1'b1, 8'hA3});
        q_exp.push_back({2'd0, 8'h55});
        q_exp.push_back({2'd0, 8'hA3});
        reset_n = 1'b1;
        for (int t = 0; t < 200 && q_exp.size() != 0; t++) cyc();
        n_tests++; if (q_exp.size() != 0) begin n_fail++; $display("FAIL single_drain: got %0d loads pending, required 0", q_exp.size()); end
        for (int t = 0; t < 50 && tx_empty !== 1'b1; t++) cyc();
        n_tests++; if (tx_empty !== 1'b1) begin n_fail++; $display("FAIL single_empty_rise: got %b, required 1", tx_empty); end
        k = 0;
        while (k < 20 && tx_enable === 1'b1) begin
            cyc();
            k++;
        end
        n_tests++; if (k != 1 + c_GAP) begin n_fail++; $display("FAIL single_enable_fall: got %0d cycles, required %0d", k, 1 + c_GAP); end
        n_tests++; if (acks[0] != 2) begin n_fail++; $display("FAIL single_acks: got %0d, required 2", acks[0]); end
    endtask

    task automatic test_lock();
        do_reset();
        q_req[0].push_back({1'b0, 8'h11});
        q_req[0].push_back({1'b0, 8'h22});
        q_req[0].push_back({1'b1, 8'h33});
        q_exp.push_back({2'd0, 8'h11});
        q_exp.push_back({2'd0, 8'h22});
        q_exp.push_back({2'd0, 8'h33});
        q_exp.push_back({2'd2, 8'h44});
        reset_n = 1'b1;
        for (int t = 0; t < 100 && acks[0] < 1; t++) cyc();
        q_req[2].push_back({1'b1, 8'h44});
        for (int t = 0; t < 100 && acks[0] < 3; t++) begin
            cyc();
            n_tests++;
            if (req_ack[2] !== 1'b0 || grant === 4'b0100) begin
                n_fail++;
                $display("FAIL lock_hold: got ack=%b grant=%b, required no service of requester 2", req_ack, grant);
            end
        end
        for (int t = 0; t < 100 && q_exp.size() != 0; t++) cyc();
        n_tests++; if (q_exp.size() != 0 || acks[2] != 1) begin n_fail++; $display("FAIL lock_handover: got pending=%0d acks2=%0d, required 0/1", q_exp.size(), acks[2]); end
    endtask

    task automatic test_stall();
        do_reset();
        stall = 1'b1;
        q_req[0].push_back({1'b1, 8'h5A});
        q_exp.push_back({2'd0, 8'h5A});
        reset_n = 1'b1;
        cyc();
        cyc();
        for (int t = 0; t < 100; t++) begin
            cyc();
            n_tests++;
            if (ld_tx_data !== 1'b0 || req_ack !== 4'b0 || grant !== 4'b0001) begin
                n_fail++;
                $display("FAIL stall_hold: got ld=%b ack=%b grant=%b, required 0/0000/0001", ld_tx_data, req_ack, grant);
            end
        end
        stall = 1'b0;
        for (int t = 0; t < 5 && tx_empty !== 1'b1; t++) cyc();
        cyc();
        n_tests++; if (ld_tx_data !== 1'b1) begin n_fail++; $display("FAIL stall_release_ld: got %b, required 1", ld_tx_data); end
        repeat (15) cyc();
        n_tests++; if (q_exp.size() != 0) begin n_fail++; $display("FAIL stall_drain: got %0d loads pending, required 0", q_exp.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        q_req[0].push_back({1'b0, 8'h66});
        q_req[0].push_back({1'b1, 8'h77});
        q_req[1].push_back({1'b1, 8'h88});
        q_exp.push_back({2'd0, 8'h66});
        reset_n = 1'b1;
        for (int t = 0; t < 50 && q_exp.size() != 0; t++) cyc();
        cyc();
        cyc();
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (grant !== 4'b0 || req_ack !== 4'b0 || ld_tx_data !== 1'b0 || tx_data !== 8'h00 ||
            tx_enable !== 1'b0 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got grant=%b ack=%b ld=%b data=%h en=%b to=%b, required all zero",
                     grant, req_ack, ld_tx_data, tx_data, tx_enable, timeout_err);
        end
        busy        = 0;
        last_ld_cyc = -100;
        q_exp.push_back({2'd0, 8'h77});
        q_exp.push_back({2'd1, 8'h88});
        cyc();
        reset_n = 1'b1;
        cyc();
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL midreset_first_edge: got %b, required 0000", grant); end
        cyc();
        n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL midreset_regrant: got %b, required 0001", grant); end
        for (int t = 0; t < 200 && q_exp.size() != 0; t++) cyc();
        n_tests++; if (q_exp.size() != 0 || acks[0] != 2 || acks[1] != 1) begin n_fail++; $display("FAIL midreset_drain: got pending=%0d acks0=%0d acks1=%0d, required 0/2/1", q_exp.size(), acks[0], acks[1]); end
    endtask

    task automatic test_timeout();
`ifdef UART_ARB_TIMEOUT_EN
        int k;
        do_reset();
        q_req[1].push_back({1'b0, 8'hA1});
        q_req[1].push_back({1'b1, 8'hB2});
        q_req[2].push_back({1'b1, 8'hC3});
        q_exp.push_back({2'd1, 8'hA1});
        q_exp.push_back({2'd2, 8'hC3});
        reset_n = 1'b1;
        for (int t = 0; t < 50 && acks[1] < 1; t++) cyc();
        en[1] = 1'b0;
        for (int t = 0; t < 50 && tx_empty !== 1'b1; t++) cyc();
        k = 0;
        while (k < 100 && timeout_err !== 1'b1) begin
            cyc();
            k++;
        end
        n_tests++; if (k != 1 + c_GAP + c_TIMEOUT) begin n_fail++; $display("FAIL timeout_latency: got %0d cycles, required %0d", k, 1 + c_GAP + c_TIMEOUT); end
        n_tests++; if (grant !== 4'b0 || tx_enable !== 1'b0) begin n_fail++; $display("FAIL timeout_release: got grant=%b en=%b, required 0000/0", grant, tx_enable); end
        cyc();
        n_tests++; if (timeout_err !== 1'b0 || grant !== 4'b0100) begin n_fail++; $display("FAIL timeout_next: got to=%b grant=%b, required 0/0100", timeout_err, grant); end
        for (int t = 0; t < 100 && q_exp.size() != 0; t++) cyc();
        n_tests++; if (q_exp.size() != 0) begin n_fail++; $display("FAIL timeout_drain: got %0d loads pending, required 0", q_exp.size()); end
        q_req[1].delete();
`else
        do_reset();
        q_req[0].push_back({1'b0, 8'hD1});
        q_req[0].push_back({1'b1, 8'hD2});
        q_exp.push_back({2'd0, 8'hD1});
        q_exp.push_back({2'd0, 8'hD2});
        reset_n = 1'b1;
        for (int t = 0; t < 50 && acks[0] < 1; t++) cyc();
        en[0] = 1'b0;
        for (int t = 0; t < 60; t++) begin
            cyc();
            n_tests++;
            if (timeout_err !== 1'b0 || grant !== 4'b0001 || ld_tx_data !== 1'b0) begin
                n_fail++;
                $display("FAIL no_timeout_hold: got to=%b grant=%b ld=%b, required 0/0001/0", timeout_err, grant, ld_tx_data);
            end
        end
        en[0] = 1'b1;
        for (int t = 0; t < 50 && q_exp.size() != 0; t++) cyc();
        n_tests++; if (q_exp.size() != 0 || acks[0] != 2) begin n_fail++; $display("FAIL no_timeout_resume: got pending=%0d acks0=%0d, required 0/2", q_exp.size(), acks[0]); end
`endif
    endtask

    initial begin
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) acks[i] = 0;
        test_reset();
        test_contention();
        test_single();
        test_lock();
        test_stall();
        test_reset_mid();
        test_timeout();
        repeat (5) cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
